// File: rtl/fifo_upsize_packer.sv
// rtl/fifo_upsize_packer.sv - width-upsizing FWFT FIFO packing RATIO narrow words per entry
module fifo_upsize_packer #(
    parameter int IN_WIDTH  = 72,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 16,
    parameter bit PAD_FLUSH = 1'b1
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [IN_WIDTH-1:0]         din,
    input  logic                        wr_en,
    output logic                        full,
    input  logic                        flush,
    input  logic                        rd_en,
    output logic [IN_WIDTH*RATIO-1:0]   dout,
    output logic [RATIO-1:0]            dout_lane_vld,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        err_ovf,
    output logic                        err_udf
);
    localparam int DW    = IN_WIDTH * RATIO;
    localparam int EW    = DW + RATIO;
    localparam int IDX_W = $clog2(RATIO);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Lane k of an entry occupies data bits [k*IN_WIDTH +: IN_WIDTH]; lane RATIO-1 is the MS lane.
    logic [RATIO-1:1][IN_WIDTH-1:0] lane_q, lane_n;
    logic [IDX_W-1:0]               idx_q, idx_n;
    logic                           pend_q, pend_n;
    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               cnt_q;
    logic                           ovf_q, udf_q;
    logic [EW-1:0]                  mem [DEPTH];

    logic          fifo_full;
    logic          wr_acc;
    logic          pop;
    logic          push;
    logic [EW-1:0] push_ent;
    logic [EW-1:0] head;

    // Build a zero-padded entry {mask, data} holding only the 'filled' most-significant lanes.
    function automatic logic [EW-1:0] partial_entry(input logic [RATIO-1:1][IN_WIDTH-1:0] lanes,
                                                    input logic [IDX_W-1:0] filled);
        logic [RATIO-1:0] m;
        logic [DW-1:0]    d;
        m = '0;
        d = '0;
        for (int k = 1; k < RATIO; k++) begin
            if (k >= RATIO - int'(filled)) begin
                m[k]                        = 1'b1;
                d[k*IN_WIDTH +: IN_WIDTH]   = lanes[k];
            end
        end
        return {m, d};
    endfunction

    assign fifo_full     = (cnt_q == CNT_FULL);
    assign full          = (fifo_full && (idx_q == IDX_LAST)) || pend_q;
    assign empty         = (cnt_q == '0);
    assign count         = cnt_q;
    assign wr_acc        = wr_en && !full;
    assign pop           = rd_en && !empty;
    assign head          = mem[rd_ptr];
    assign dout          = empty ? '0 : head[DW-1:0];
    assign dout_lane_vld = empty ? '0 : head[EW-1:DW];
    assign err_ovf       = ovf_q;
    assign err_udf       = udf_q;

    // Absorb the incoming word first, then let a pending or new flush act on the result.
    always_comb begin
        lane_n   = lane_q;
        idx_n    = idx_q;
        pend_n   = pend_q;
        push     = 1'b0;
        push_ent = '0;
        if (wr_acc) begin
            if (idx_q == IDX_LAST) begin
                push     = 1'b1;
                push_ent = {{RATIO{1'b1}}, lane_q, din};
                idx_n    = '0;
                lane_n   = '0;
            end else begin
                for (int k = 1; k < RATIO; k++) begin
                    if (k == RATIO - 1 - int'(idx_q)) begin
                        lane_n[k] = din;
                    end
                end
                idx_n = idx_q + 1'b1;
            end
        end
        if (pend_q) begin
            // A deferred flush waits for space made visible by an earlier pop.
            if (!fifo_full) begin
                push     = 1'b1;
                push_ent = partial_entry(lane_q, idx_q);
                idx_n    = '0;
                lane_n   = '0;
                pend_n   = 1'b0;
            end
        end else if (flush && (idx_n != '0)) begin
            if (PAD_FLUSH) begin
                if (!fifo_full) begin
                    push     = 1'b1;
                    push_ent = partial_entry(lane_n, idx_n);
                    idx_n    = '0;
                    lane_n   = '0;
                end else begin
                    pend_n = 1'b1;
                end
            end else begin
                idx_n  = '0;
                lane_n = '0;
            end
        end
    end

    // Assembly state, pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            lane_q <= '0;
            idx_q  <= '0;
            pend_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            lane_q <= lane_n;
            idx_q  <= idx_n;
            pend_q <= pend_n;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
            if (rd_en && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    // Entry storage; contents are only observable through dout while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end
endmodule

// File: tb/tb_fifo_upsize_packer.sv
// tb/tb_fifo_upsize_packer.sv - directed table-driven bench for fifo_upsize_packer
module tb_fifo_upsize_packer;
    logic clk;
    logic arst_n;

    // Instance A: RATIO=2, DEPTH=4, padded flush
    logic [7:0]  din_a;
    logic        wr_a, flush_a, rd_a;
    logic        full_a, empty_a, ovf_a, udf_a;
    logic [15:0] dout_a;
    logic [1:0]  vld_a;
    logic [2:0]  cnt_a;

    // Instances B (padded) and C (discard): RATIO=4, DEPTH=4, shared write side
    logic [7:0]  din_bc;
    logic        wr_bc, flush_bc, rd_b, rd_c;
    logic        full_b, empty_b, ovf_b, udf_b;
    logic        full_c, empty_c, ovf_c, udf_c;
    logic [31:0] dout_b, dout_c;
    logic [3:0]  vld_b, vld_c;
    logic [2:0]  cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;

    fifo_upsize_packer #(.IN_WIDTH(8), .RATIO(2), .DEPTH(4), .PAD_FLUSH(1'b1)) u_a (
        .clk(clk), .arst_n(arst_n), .din(din_a), .wr_en(wr_a), .full(full_a), .flush(flush_a),
        .rd_en(rd_a), .dout(dout_a), .dout_lane_vld(vld_a), .empty(empty_a), .count(cnt_a),
        .err_ovf(ovf_a), .err_udf(udf_a));

    fifo_upsize_packer #(.IN_WIDTH(8), .RATIO(4), .DEPTH(4), .PAD_FLUSH(1'b1)) u_b (
        .clk(clk), .arst_n(arst_n), .din(din_bc), .wr_en(wr_bc), .full(full_b), .flush(flush_bc),
        .rd_en(rd_b), .dout(dout_b), .dout_lane_vld(vld_b), .empty(empty_b), .count(cnt_b),
        .err_ovf(ovf_b), .err_udf(udf_b));

    fifo_upsize_packer #(.IN_WIDTH(8), .RATIO(4), .DEPTH(4), .PAD_FLUSH(1'b0)) u_c (
        .clk(clk), .arst_n(arst_n), .din(din_bc), .wr_en(wr_bc), .full(full_c), .flush(flush_bc),
        .rd_en(rd_c), .dout(dout_c), .dout_lane_vld(vld_c), .empty(empty_c), .count(cnt_c),
        .err_ovf(ovf_c), .err_udf(udf_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [7:0]  d;
        logic        fl;
        logic        rd;
        logic        full;
        logic        empty;
        logic [2:0]  cnt;
        logic [15:0] dout;
        logic [1:0]  vld;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic fl, input logic rd,
                                input logic fu, input logic em, input logic [2:0] c,
                                input logic [15:0] o, input logic [1:0] m);
        mk = '{wr, d, fl, rd, fu, em, c, o, m};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle on the B/C pair: inputs driven at negedge, sampled at posedge, back to idle.
    task automatic cyc_bc(input logic w, input logic [7:0] d, input logic f, input logic rb);
        wr_bc = w; din_bc = d; flush_bc = f; rd_b = rb; rd_c = 1'b0;
        @(negedge clk);
        wr_bc = 1'b0; din_bc = '0; flush_bc = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0;
        din_a = '0; wr_a = 1'b0; flush_a = 1'b0; rd_a = 1'b0;
        din_bc = '0; wr_bc = 1'b0; flush_bc = 1'b0; rd_b = 1'b0; rd_c = 1'b0;

        // Expected state is checked before the row's inputs are applied.
        tbl[0]  = mk(1, 8'hA1, 0, 0, 0, 1, 0, 16'h0000, 2'b00);
        tbl[1]  = mk(1, 8'hA2, 0, 0, 0, 1, 0, 16'h0000, 2'b00);
        tbl[2]  = mk(1, 8'hB1, 0, 1, 0, 0, 1, 16'hA1A2, 2'b11);
        tbl[3]  = mk(1, 8'hB2, 0, 0, 0, 1, 0, 16'h0000, 2'b00);
        tbl[4]  = mk(0, 8'h00, 0, 1, 0, 0, 1, 16'hB1B2, 2'b11);
        tbl[5]  = mk(1, 8'h10, 0, 0, 0, 1, 0, 16'h0000, 2'b00);
        tbl[6]  = mk(1, 8'h11, 0, 0, 0, 1, 0, 16'h0000, 2'b00);
        tbl[7]  = mk(1, 8'h12, 0, 0, 0, 0, 1, 16'h1011, 2'b11);
        tbl[8]  = mk(1, 8'h13, 0, 0, 0, 0, 1, 16'h1011, 2'b11);
        tbl[9]  = mk(1, 8'h14, 0, 0, 0, 0, 2, 16'h1011, 2'b11);
        tbl[10] = mk(1, 8'h15, 0, 0, 0, 0, 2, 16'h1011, 2'b11);
        tbl[11] = mk(1, 8'h16, 0, 0, 0, 0, 3, 16'h1011, 2'b11);
        tbl[12] = mk(1, 8'h17, 0, 0, 0, 0, 3, 16'h1011, 2'b11);
        tbl[13] = mk(1, 8'h21, 0, 0, 0, 0, 4, 16'h1011, 2'b11);
        tbl[14] = mk(1, 8'h22, 0, 0, 1, 0, 4, 16'h1011, 2'b11);
        tbl[15] = mk(1, 8'h22, 0, 1, 1, 0, 4, 16'h1011, 2'b11);
        tbl[16] = mk(1, 8'h22, 0, 0, 0, 0, 3, 16'h1213, 2'b11);
        tbl[17] = mk(1, 8'h31, 0, 0, 0, 0, 4, 16'h1213, 2'b11);
        tbl[18] = mk(0, 8'h00, 1, 0, 1, 0, 4, 16'h1213, 2'b11);
        tbl[19] = mk(0, 8'h00, 0, 0, 1, 0, 4, 16'h1213, 2'b11);
        tbl[20] = mk(0, 8'h00, 0, 1, 1, 0, 4, 16'h1213, 2'b11);
        tbl[21] = mk(0, 8'h00, 0, 0, 1, 0, 3, 16'h1415, 2'b11);
        tbl[22] = mk(0, 8'h00, 0, 1, 0, 0, 4, 16'h1415, 2'b11);
        tbl[23] = mk(0, 8'h00, 0, 1, 0, 0, 3, 16'h1617, 2'b11);
        tbl[24] = mk(0, 8'h00, 0, 1, 0, 0, 2, 16'h2122, 2'b11);
        tbl[25] = mk(0, 8'h00, 0, 1, 0, 0, 1, 16'h3100, 2'b10);
        tbl[26] = mk(0, 8'h00, 0, 0, 0, 1, 0, 16'h0000, 2'b00);

        repeat (2) @(negedge clk);
        chk("rst_full", 64'(full_a), 64'(1'b0));
        chk("rst_empty", 64'(empty_a), 64'(1'b1));
        chk("rst_errs", 64'({ovf_a, udf_a}), 64'(2'b00));
        arst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d_full", i), 64'(full_a), 64'(tbl[i].full));
            chk($sformatf("v%0d_empty", i), 64'(empty_a), 64'(tbl[i].empty));
            chk($sformatf("v%0d_count", i), 64'(cnt_a), 64'(tbl[i].cnt));
            chk($sformatf("v%0d_dout", i), 64'(dout_a), 64'(tbl[i].dout));
            chk($sformatf("v%0d_vld", i), 64'(vld_a), 64'(tbl[i].vld));
            wr_a = tbl[i].wr; din_a = tbl[i].d; flush_a = tbl[i].fl; rd_a = tbl[i].rd;
            @(negedge clk);
        end
        wr_a = 1'b0; din_a = '0; flush_a = 1'b0; rd_a = 1'b0;
        chk("a_ovf_set", 64'(ovf_a), 64'(1'b1));
        chk("a_udf_clear", 64'(udf_a), 64'(1'b0));

        // Underflow: pop while empty
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
        chk("udf_set", 64'(udf_a), 64'(1'b1));
        chk("udf_count", 64'(cnt_a), 64'(0));
        chk("udf_empty", 64'(empty_a), 64'(1'b1));

        // Asynchronous reset mid-packet drops the residue
        wr_a = 1'b1; din_a = 8'h41;
        @(negedge clk);
        wr_a = 1'b0; din_a = '0;
        #2 arst_n = 1'b0;
        #1;
        chk("arst_full", 64'(full_a), 64'(1'b0));
        chk("arst_empty", 64'(empty_a), 64'(1'b1));
        chk("arst_count", 64'(cnt_a), 64'(0));
        chk("arst_dout", 64'({dout_a, vld_a}), 64'(0));
        chk("arst_errs", 64'({ovf_a, udf_a}), 64'(2'b00));
        @(negedge clk);
        arst_n = 1'b1;
        wr_a = 1'b1; din_a = 8'h51;
        @(negedge clk);
        din_a = 8'h52;
        @(negedge clk);
        wr_a = 1'b0; din_a = '0;
        chk("post_rst_dout", 64'(dout_a), 64'(16'h5152));
        chk("post_rst_vld", 64'(vld_a), 64'(2'b11));
        chk("post_rst_count", 64'(cnt_a), 64'(1));

        // RATIO=4: two words then a standalone flush
        cyc_bc(1, 8'h01, 0, 0);
        cyc_bc(1, 8'h02, 0, 0);
        cyc_bc(0, 8'h00, 1, 0);
        chk("b_flush_count", 64'(cnt_b), 64'(1));
        chk("b_flush_dout", 64'(dout_b), 64'(32'h0102_0000));
        chk("b_flush_vld", 64'(vld_b), 64'(4'b1100));
        chk("c_flush_empty", 64'(empty_c), 64'(1'b1));

        // Three words with flush on the third
        cyc_bc(1, 8'h03, 0, 0);
        cyc_bc(1, 8'h04, 0, 0);
        cyc_bc(1, 8'h05, 1, 0);
        chk("b_wrfl_count", 64'(cnt_b), 64'(2));
        chk("c_wrfl_count", 64'(cnt_c), 64'(0));

        // Four more words form a full entry in both
        cyc_bc(1, 8'h06, 0, 0);
        cyc_bc(1, 8'h07, 0, 0);
        cyc_bc(1, 8'h08, 0, 0);
        cyc_bc(1, 8'h09, 0, 0);
        chk("b_full_count", 64'(cnt_b), 64'(3));
        chk("c_full_count", 64'(cnt_c), 64'(1));
        chk("c_full_dout", 64'(dout_c), 64'(32'h0607_0809));
        chk("c_full_vld", 64'(vld_c), 64'(4'b1111));

        // Flush with no residue is a no-op
        cyc_bc(0, 8'h00, 1, 0);
        chk("b_noop_count", 64'(cnt_b), 64'(3));
        chk("c_noop_count", 64'(cnt_c), 64'(1));
        chk("b_noop_full", 64'(full_b), 64'(1'b0));

        // Drain B to inspect the second and third entries
        cyc_bc(0, 8'h00, 0, 1);
        chk("b_pop1_dout", 64'(dout_b), 64'(32'h0304_0500));
        chk("b_pop1_vld", 64'(vld_b), 64'(4'b1110));
        cyc_bc(0, 8'h00, 0, 1);
        chk("b_pop2_dout", 64'(dout_b), 64'(32'h0607_0809));
        chk("b_pop2_vld", 64'(vld_b), 64'(4'b1111));
        chk("b_pop2_count", 64'(cnt_b), 64'(1));
        chk("bc_errs", 64'({ovf_b, udf_b, ovf_c, udf_c, full_c}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_upsize_packer.md
# fifo_upsize_packer

Single-clock, parametrised width-upsizing FIFO: packs RATIO consecutive IN_WIDTH-bit write words into one IN_WIDTH*RATIO-bit entry and buffers DEPTH such entries for a first-word-fall-through reader. It generalises the fixed 72-to-144 DRAM-path packer used on the DDR2 block read/write datapath to any ratio and depth. It adds a flush mode that emits a zero-padded partial entry with a lane-valid mask, and it keeps sticky error flags. It sits between a narrow streaming producer and a wide consumer in the same clock domain.

## Interface
- IN_WIDTH, 72, width of one write word
- RATIO, 2, write words per FIFO entry; integer >= 2
- DEPTH, 16, FIFO entries; power of two >= 2
- PAD_FLUSH, 1, 1: flush writes a padded partial entry; 0: flush discards the residue
- clk  in  1  single clock; all logic rising-edge
- arst_n  in  1  asynchronous, active-low reset
- din  in  IN_WIDTH  write data, sampled in the same cycle as wr_en
- wr_en  in  1  write strobe; accepted when wr_en & ~full
- full  out  1  write-side back-pressure
- flush  in  1  single-cycle request to close the partial entry
- rd_en  in  1  pop strobe; honoured when ~empty
- dout  out  IN_WIDTH*RATIO  head entry; first-written word in the most-significant lane
- dout_lane_vld  out  RATIO  per-lane valid of head entry; bit RATIO-1 = MS lane
- empty  out  1  no entry available
- count  out  $clog2(DEPTH)+1  entries stored
- err_ovf  out  1  sticky: wr_en while full
- err_udf  out  1  sticky: rd_en while empty

## Operation
- Assembly stage: RATIO-1 lane registers, lane index idx (0..RATIO-1), flush_pend flag.
- Accepted word, idx < RATIO-1: store in lane (RATIO-1-idx); idx++.
- Accepted word, idx == RATIO-1: write {lanes, din} to FIFO with mask all ones; idx <= 0.
- full = (fifo_full & idx == RATIO-1) | flush_pend. Words for non-final lanes are accepted even when the FIFO is full.
- flush with idx == 0 after any same-cycle word: no-op.
- flush, PAD_FLUSH=1, FIFO not full: write the partial entry. Unfilled lanes are zero, and the mask sets only the filled MS lanes. idx <= 0.
- flush, PAD_FLUSH=1, FIFO full: set flush_pend; full is held high. The partial entry is written on the first cycle the FIFO has space; flush_pend then clears.
- flush, PAD_FLUSH=0: lanes cleared, idx <= 0, nothing written.
- wr_en & flush in the same cycle: the word is absorbed first, then flush acts on the result.
  - If the word completed the entry, flush is a no-op.
  - If PAD_FLUSH=0, the absorbed word is discarded with the residue.
- flush while flush_pend: ignored.
- Storage: DEPTH x (IN_WIDTH*RATIO + RATIO) array with binary pointers, combinational read at rd_ptr.
- dout = 0 and dout_lane_vld = 0 whenever empty.
- rd_en & ~empty: rd_ptr++. Simultaneous read and write: count unchanged, both pointers advance.
- Pointers wrap at DEPTH. count range is 0..DEPTH. fifo_full = (count == DEPTH).
- err_ovf and err_udf are set on the offending cycle and cleared only by arst_n. Offending requests have no other effect.

## Timing
- Reset values (async, all regs):
  - idx = 0, flush_pend = 0, lanes = 0, pointers = 0, count = 0
  - full = 0, empty = 1, dout = 0, dout_lane_vld = 0, err_ovf = 0, err_udf = 0
- Write latency: completing word or flush write at edge t → empty = 0, count++ and head visible on dout after edge t (cycle t+1).
- Read: dout valid whenever ~empty (FWFT). After the popping edge, the next entry or zero is shown.
- full, empty and count are registered-state functions only; there is no combinational path from wr_en, rd_en or flush.
- A read at cycle t frees space visible at cycle t+1.
  - With the FIFO full, a simultaneous read does not lower full in the same cycle.
  - A pending flush writes at t+1.
- Reset asserted mid-packet: residue and pending flush are lost. Outputs take reset values asynchronously.

## Test plan
- RATIO=2, write A1,A2,B1,B2 back-to-back, rd_en held → dout = {A1,A2} then {B1,B2}; mask = 2'b11; first entry visible at cycle 2 after A1; count peaks at 1.
- RATIO=4, PAD_FLUSH=1, write W0,W1 then flush → one entry {W0,W1,0,0}, dout_lane_vld = 4'b1100; next words start at lane 3.
- RATIO=4, PAD_FLUSH=0, write W0,W1,W2 with flush on W2 → nothing written; next four words form a full entry, count = 1.
- DEPTH=4, RATIO=2, fill 4 entries, then:
  - write X1 → accepted, and full rises (idx = 1).
  - write X2 → blocked, err_ovf = 1.
  - one pop → X2 accepted the next cycle, count = 4.
- DEPTH=4, FIFO full, idx = 1, PAD_FLUSH=1, flush → flush_pend = 1 and full = 1 until a pop; partial entry written the cycle after the pop with mask 2'b10.
- rd_en while empty → err_udf = 1, count stays 0. Then assert arst_n low mid-packet → all outputs return to reset values, with empty = 1.
